// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module  : serial_subtractor_pkg
// Purpose : Shared FSM encoding and sizing constants for serial_subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sub_state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_adder_1b.sv
// ============================================================================
// Module  : full_adder_1b
// Purpose : One-bit full adder; the serial subtractor's per-bit datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Purpose : Bit-serial two's-complement a - b, LSB first, with signed overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sub_state_e       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_ovf;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  // a - b computed as a + ~b + 1: the borrow chain starts with carry = 1.
  full_adder_1b u_fa (
    .a    (r_sa[0]),
    .b    (~r_sb[0]),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_res   <= w_res_next;
          r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Final bit: w_sum is the result MSB, so overflow can be judged now.
          if (r_cnt == LAST_CNT) begin
            r_diff  <= w_res_next;
            r_ovf   <= (r_a_msb != r_b_msb) && (w_sum != r_a_msb);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign diff     = r_diff;
  assign overflow = r_ovf;

endmodule

`default_nettype wire
